// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: scans the enabled analog channels in ascending order. For each
// channel it resets the SAR logic, discards the first conversion, averages
// 2^avg_log2 conversions and offers the result on a valid/ready output.
module sar_scan_ctrl #(
    parameter int NCH      = 4,
    parameter int RES_BITS = 10,
    parameter int PREP_CYC = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NCH-1:0]         chan_mask,
    input  logic [1:0]             avg_log2,
    input  logic                   adc_clk_sample,
    input  logic [RES_BITS-1:0]    adc_result,
    output logic                   adc_reset_n,
    output logic [$clog2(NCH)-1:0] mux_sel,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(NCH)-1:0] out_chan,
    output logic [RES_BITS-1:0]    out_data,
    output logic                   done
);

    localparam int CW    = $clog2(NCH);
    localparam int ACC_W = RES_BITS + 3;
    localparam int PW    = $clog2(PREP_CYC);
    localparam logic [PW-1:0] PREP_LAST = PW'(PREP_CYC - 1);

    typedef enum logic [2:0] {IDLE, PREP, DISCARD, ACC, OUT} state_t;

    state_t               state_q, state_d;
    logic [NCH-1:0]       mask_q, mask_d;
    logic [1:0]           avg_q, avg_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [PW-1:0]        prep_cnt_q, prep_cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [3:0]           smp_cnt_q, smp_cnt_d;
    logic [RES_BITS-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]        out_chan_q, out_chan_d;
    logic                 done_q, done_d;
    logic                 prev_q, prev_d;

    logic                 rise;
    logic                 smp_last;
    logic [ACC_W-1:0]     acc_sum;
    logic [CW-1:0]        first_chan;
    logic [CW-1:0]        next_chan;
    logic                 has_next;

    // The SAR logic is held in reset everywhere except while conversions are collected.
    assign adc_reset_n = (state_q == DISCARD) || (state_q == ACC);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == OUT);
    assign mux_sel     = chan_q;
    assign out_chan    = out_chan_q;
    assign out_data    = out_data_q;
    assign done        = done_q;

    assign rise     = adc_clk_sample & ~prev_q;
    assign acc_sum  = acc_q + ACC_W'(adc_result);
    assign smp_last = (smp_cnt_q == ((4'd1 << avg_q) - 4'd1));

    // Lowest channel of the incoming mask and next higher channel of the latched mask.
    always_comb begin
        first_chan = '0;
        next_chan  = '0;
        has_next   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_chan = CW'(i);
            end
            if (mask_q[i] && (i > int'(chan_q))) begin
                next_chan = CW'(i);
                has_next  = 1'b1;
            end
        end
    end

    // Next-state logic for the scan sequencer; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        avg_d      = avg_q;
        chan_d     = chan_q;
        prep_cnt_d = prep_cnt_q;
        acc_d      = acc_q;
        smp_cnt_d  = smp_cnt_q;
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        done_d     = 1'b0;
        prev_d     = adc_reset_n & adc_clk_sample;

        case (state_q)
            IDLE: begin
                if (start && (chan_mask != '0)) begin
                    mask_d     = chan_mask;
                    avg_d      = avg_log2;
                    chan_d     = first_chan;
                    prep_cnt_d = '0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                acc_d     = '0;
                smp_cnt_d = '0;
                if (prep_cnt_q == PREP_LAST) begin
                    prep_cnt_d = '0;
                    state_d    = DISCARD;
                end else begin
                    prep_cnt_d = prep_cnt_q + 1'b1;
                end
            end
            DISCARD: begin
                // First conversion after reset is unreliable and is dropped.
                if (rise) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (rise) begin
                    acc_d     = acc_sum;
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (smp_last) begin
                        out_data_d = RES_BITS'(acc_sum >> avg_q);
                        out_chan_d = chan_q;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (has_next) begin
                        chan_d     = next_chan;
                        prep_cnt_d = '0;
                        state_d    = PREP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            prep_cnt_d = '0;
            done_d     = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            avg_q      <= '0;
            chan_q     <= '0;
            prep_cnt_q <= '0;
            acc_q      <= '0;
            smp_cnt_q  <= '0;
            out_data_q <= '0;
            out_chan_q <= '0;
            done_q     <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            avg_q      <= avg_d;
            chan_q     <= chan_d;
            prep_cnt_q <= prep_cnt_d;
            acc_q      <= acc_d;
            smp_cnt_q  <= smp_cnt_d;
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
            done_q     <= done_d;
            prev_q     <= prev_d;
        end
    end

endmodule

// File: doc/sar_scan_ctrl.md
SAR_SCAN_CTRL -- requirements
Module: sar_scan_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of analog input channels (2..8).
REQ-002 SHALL have parameter RES_BITS, default 10, the width of the ADC result word.
REQ-003 SHALL have parameter PREP_CYC, default 2, the cycles adc_reset_n is held low before each channel burst (min 2).
REQ-004 clock  input  1  single system clock; all logic on posedge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  scan request, sampled on a clock edge.
REQ-007 abort  input  1  synchronous scan cancel.
REQ-008 chan_mask  input  NCH  channels to convert; bit i enables channel i.
REQ-009 avg_log2  input  2  samples averaged per channel = 2^avg_log2 (1, 2, 4 or 8).
REQ-010 adc_clk_sample  input  1  clk_sample output of the SAR logic.
REQ-011 adc_result  input  RES_BITS  result output of the SAR logic.
REQ-012 adc_reset_n  output  1  synchronous active-low reset driven to the SAR logic.
REQ-013 mux_sel  output  clog2(NCH)  analog input mux select.
REQ-014 busy  output  1  high while a scan is in progress.
REQ-015 out_valid  output  1  averaged result available.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_chan  output  clog2(NCH)  channel of out_data.
REQ-018 out_data  output  RES_BITS  averaged result.
REQ-019 done  output  1  one-cycle pulse when a scan completes.

Function
REQ-020 States SHALL be IDLE, PREP, DISCARD, ACC and OUT.
REQ-021 In IDLE, when start=1 and chan_mask!=0, the block SHALL latch chan_mask and avg_log2, select the lowest enabled channel, and go to PREP; when start=1 and chan_mask=0 it SHALL stay in IDLE with busy=0.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 PREP SHALL drive adc_reset_n=0 with mux_sel equal to the current channel for exactly PREP_CYC cycles, clear the accumulator and sample counter, and then go to DISCARD.
REQ-024 A "rise" SHALL be defined as adc_clk_sample=1 while its registered previous value is 0; the previous-value register SHALL be forced to 0 whenever adc_reset_n is low.
REQ-025 DISCARD SHALL drive adc_reset_n=1, drop the adc_result present at the first rise, and go to ACC.
REQ-026 In ACC, on each rise adc_result SHALL be added into an accumulator of width RES_BITS+3; after 2^avg_log2 rises the block SHALL go to OUT.
REQ-027 On entering OUT, out_data SHALL equal accumulator >> avg_log2 (truncating) and out_chan SHALL equal the current channel. adc_reset_n SHALL be 0 and out_valid SHALL be 1 throughout OUT.
REQ-028 out_valid, out_data and out_chan SHALL stay stable until a cycle with out_valid=1 and out_ready=1. In that cycle the result is accepted, and out_valid SHALL be 0 on the next cycle.
REQ-029 On acceptance, the block SHALL go to PREP for the next higher enabled channel if one exists. Otherwise it SHALL go to IDLE and pulse done for the one following cycle.
REQ-030 Channels SHALL be converted once each per scan, in ascending index order, and disabled channels SHALL be skipped.
REQ-031 busy SHALL be 1 in PREP, DISCARD, ACC and OUT, and 0 in IDLE.
REQ-032 abort=1 in any state SHALL return the block to IDLE on the next edge with adc_reset_n=0, out_valid=0 and no done pulse; abort SHALL take priority over start and out_ready.
REQ-033 Accumulation SHALL never overflow: 8 x (2^RES_BITS - 1) fits in RES_BITS+3 bits.

Reset
REQ-034 While reset_n=0 the block SHALL enter IDLE with adc_reset_n=0, mux_sel=0, busy=0, out_valid=0, out_chan=0, out_data=0, done=0, and the accumulator, counter and latched configuration all cleared.
REQ-035 Reset applied mid-scan SHALL discard all partial results, and SHALL produce no done pulse and no out_valid.

Verification
REQ-036 The bench SHALL pair the block with the SAR logic (or an equivalent model) and cover the following scenarios.
- V1: chan_mask=0100, avg_log2=0, model returns 0x155 -> mux_sel=2 during the burst; out_valid with out_chan=2, out_data=0x155; after acceptance, done pulses once and busy=0.
- V2: chan_mask=0001, avg_log2=2, samples after the discarded one are 100,102,104,106 -> out_data=103.
- V3: chan_mask=1010, avg_log2=3, every sample 0x3FF -> results for channel 1 and then channel 3, both 0x3FF; one done pulse.
- V4: out_ready held 0 for 20 cycles in OUT -> out_valid, out_data and out_chan stable and adc_reset_n=0 throughout; on ready=1, acceptance occurs and the next channel proceeds.
- V5: start during ACC ignored; abort during ACC -> IDLE next cycle, busy=0, no done; start with chan_mask=0 -> busy stays 0.
- V6: reset_n=0 during OUT -> all outputs take their reset values next cycle; a new scan afterwards yields correct results.
